// File: rtl/npx_pkg.sv
// npx_pkg: shared types, constants and the per-channel brightness shift for the NeoPixel frame path
package npx_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_SEND,
      S_LATCH
   } state_t;

   localparam int LEVEL_MAX = 4;

   localparam int G_LSB = 16;
   localparam int R_LSB = 8;
   localparam int B_LSB = 0;

   // Levels above LEVEL_MAX are treated as full brightness so a bad level can never wrap the shift.
   function automatic logic [7:0] shift_by_level(input logic [7:0] v, input logic [2:0] lvl);
      return (lvl >= 3'(LEVEL_MAX)) ? v : v >> (3'(LEVEL_MAX) - lvl);
   endfunction

endpackage

// File: rtl/npx_level_scale.sv
// npx_level_scale: combinational GRB brightness shifter (grb in, level in, scaled out)
module npx_level_scale
   import npx_pkg::*;
(
   input  logic [23:0] grb,
   input  logic [2:0]  level,
   output logic [23:0] scaled
);

   always_comb begin
      scaled = {shift_by_level(grb[G_LSB +: 8], level),
                shift_by_level(grb[R_LSB +: 8], level),
                shift_by_level(grb[B_LSB +: 8], level)};
   end

endmodule

// File: rtl/npx_frame_scheduler.sv
// npx_frame_scheduler: per-frame LED fetch/scale/send sequencer with latch gap; brightness via NPX_BRIGHTNESS_EN
//   ports: clk, rst, up_pulse/down_pulse (brightness steps), pix_req/pix_idx/pix_ack/pix_grb (pattern source),
//          ser_valid/ser_data/ser_ready (serializer), latch, frame_start, level (applied brightness)
module npx_frame_scheduler
   import npx_pkg::*;
#(
   parameter int NUM_LEDS     = 60,
   parameter int LATCH_CYCLES = 1024,
   parameter int LEVEL_RESET  = 2
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        up_pulse,
   input  logic        down_pulse,
   output logic        pix_req,
   output logic [7:0]  pix_idx,
   input  logic        pix_ack,
   input  logic [23:0] pix_grb,
   output logic        ser_valid,
   output logic [23:0] ser_data,
   input  logic        ser_ready,
   output logic        latch,
   output logic        frame_start,
   output logic [2:0]  level
);

   localparam int CW = $clog2(LATCH_CYCLES) + 1;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [23:0]   scaled;
   logic          last_led;
   logic          boundary;

   assign last_led = pix_idx == 8'(NUM_LEDS - 1);
   assign boundary = state == S_LATCH && cnt == CW'(LATCH_CYCLES - 1);

   npx_level_scale u_scale (
      .grb    (pix_grb),
      .level  (level),
      .scaled (scaled)
   );

`ifdef NPX_BRIGHTNESS_EN
   logic [2:0] pending_level;
   // Pulses keep accumulating during LATCH; level only follows at the frame boundary.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_level <= 3'(LEVEL_RESET);
         level         <= 3'(LEVEL_RESET);
      end else begin
         if (up_pulse && !down_pulse && pending_level < 3'(LEVEL_MAX))
            pending_level <= pending_level + 3'd1;
         else if (down_pulse && !up_pulse && pending_level != 3'd0)
            pending_level <= pending_level - 3'd1;
         if (boundary)
            level <= pending_level;
      end
   end
`else
   logic unused_pulses;
   assign unused_pulses = up_pulse ^ down_pulse;
   assign level = 3'(LEVEL_MAX);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         pix_req     <= 1'b0;
         pix_idx     <= 8'd0;
         ser_valid   <= 1'b0;
         ser_data    <= 24'd0;
         latch       <= 1'b0;
         frame_start <= 1'b0;
         cnt         <= '0;
      end else begin
         frame_start <= 1'b0;
         case (state)
            S_IDLE: begin
               state       <= S_FETCH;
               pix_req     <= 1'b1;
               pix_idx     <= 8'd0;
               frame_start <= 1'b1;
            end
            S_FETCH: if (pix_ack) begin
               ser_data  <= scaled;
               ser_valid <= 1'b1;
               pix_req   <= 1'b0;
               state     <= S_SEND;
            end
            S_SEND: if (ser_ready) begin
               ser_valid <= 1'b0;
               if (last_led) begin
                  latch <= 1'b1;
                  cnt   <= '0;
                  state <= S_LATCH;
               end else begin
                  pix_idx <= pix_idx + 8'd1;
                  pix_req <= 1'b1;
                  state   <= S_FETCH;
               end
            end
            S_LATCH: if (boundary) begin
               latch       <= 1'b0;
               pix_idx     <= 8'd0;
               pix_req     <= 1'b1;
               frame_start <= 1'b1;
               state       <= S_FETCH;
            end else begin
               cnt <= cnt + CW'(1);
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_npx_frame_scheduler.sv
// tb_npx_frame_scheduler: directed self-checking bench for npx_frame_scheduler (3 LEDs, 1024-cycle latch)
module tb_npx_frame_scheduler;

`ifdef NPX_BRIGHTNESS_EN
   localparam bit BR = 1'b1;
`else
   localparam bit BR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, up_pulse, down_pulse, pix_ack, ser_ready;
   logic [23:0] pix_grb;
   logic        pix_req, ser_valid, latch, frame_start;
   logic [7:0]  pix_idx;
   logic [23:0] ser_data;
   logic [2:0]  level;
   int          checks = 0;
   int          errors = 0;
   int          n;

   npx_frame_scheduler #(.NUM_LEDS(3), .LATCH_CYCLES(1024), .LEVEL_RESET(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .up_pulse    (up_pulse),
      .down_pulse  (down_pulse),
      .pix_req     (pix_req),
      .pix_idx     (pix_idx),
      .pix_ack     (pix_ack),
      .pix_grb     (pix_grb),
      .ser_valid   (ser_valid),
      .ser_data    (ser_data),
      .ser_ready   (ser_ready),
      .latch       (latch),
      .frame_start (frame_start),
      .level       (level)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_req"}, 32'(pix_req), 0);
      chk({tag, "_idx"}, 32'(pix_idx), 0);
      chk({tag, "_valid"}, 32'(ser_valid), 0);
      chk({tag, "_data"}, 32'(ser_data), 0);
      chk({tag, "_latch"}, 32'(latch), 0);
      chk({tag, "_fs"}, 32'(frame_start), 0);
      chk({tag, "_level"}, 32'(level), BR ? 2 : 4);
   endtask

   task automatic wait_fs(input string tag);
      int k = 0;
      do begin
         tick();
         k++;
      end while (!frame_start && k < 3000);
      chk({tag, "_fs_seen"}, 32'(frame_start), 1);
   endtask

   initial begin
      rst = 1'b1; up_pulse = 1'b0; down_pulse = 1'b0;
      pix_ack = 1'b0; ser_ready = 1'b0; pix_grb = 24'd0;
      tick(); tick();
      chk_reset("rst0");
      rst = 1'b0;
      tick();
      chk("start_fs", 32'(frame_start), 1);
      chk("start_req", 32'(pix_req), 1);
      chk("start_idx", 32'(pix_idx), 0);
      chk("start_latch", 32'(latch), 0);
      tick();
      chk("fetch_fs_drop", 32'(frame_start), 0);
      chk("fetch_hold_req", 32'(pix_req), 1);
      up_pulse = 1'b1; down_pulse = 1'b1;
      tick();
      up_pulse = 1'b0; down_pulse = 1'b0;
      pix_grb = 24'hFF8040; pix_ack = 1'b1;
      tick();
      pix_ack = 1'b0;
      chk("ack_valid", 32'(ser_valid), 1);
      chk("ack_req_drop", 32'(pix_req), 0);
      chk("ack_data0", 32'(ser_data), BR ? 32'h3F2010 : 32'hFF8040);
      pix_grb = 24'h000000;
      for (int i = 0; i < 10; i++) begin
         up_pulse = (i == 3);
         tick();
         chk("stall_valid", 32'(ser_valid), 1);
         chk("stall_data", 32'(ser_data), BR ? 32'h3F2010 : 32'hFF8040);
         chk("stall_req", 32'(pix_req), 0);
      end
      up_pulse = 1'b0;
      chk("midframe_level", 32'(level), BR ? 2 : 4);
      ser_ready = 1'b1;
      tick();
      ser_ready = 1'b0;
      chk("accept_req", 32'(pix_req), 1);
      chk("accept_idx", 32'(pix_idx), 1);
      chk("accept_valid", 32'(ser_valid), 0);
      pix_grb = 24'h123456; pix_ack = 1'b1;
      tick();
      chk("ack_data1", 32'(ser_data), BR ? 32'h040D15 : 32'h123456);
      ser_ready = 1'b1;
      tick();
      chk("idx2", 32'(pix_idx), 2);
      chk("idx2_req", 32'(pix_req), 1);
      tick(); tick();
      chk("latch_on", 32'(latch), 1);
      chk("latch_req", 32'(pix_req), 0);
      chk("latch_valid", 32'(ser_valid), 0);
      chk("latch_level", 32'(level), BR ? 2 : 4);
      pix_ack = 1'b0; ser_ready = 1'b0;
      n = 1;
      while (latch && n < 2000) begin
         tick();
         if (latch) n++;
      end
      chk("latch_len", 32'(n), 1024);
      chk("f2_fs", 32'(frame_start), 1);
      chk("f2_req", 32'(pix_req), 1);
      chk("f2_idx", 32'(pix_idx), 0);
      chk("f2_level", 32'(level), BR ? 3 : 4);
      pix_grb = 24'hFF8040; pix_ack = 1'b1; ser_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         up_pulse = 1'b1;
         tick();
         up_pulse = 1'b0;
         tick();
      end
      wait_fs("f3");
      chk("f3_level_sat", 32'(level), 4);
      tick();
      chk("f3_valid", 32'(ser_valid), 1);
      chk("f3_data", 32'(ser_data), 32'hFF8040);
      for (int i = 0; i < 4; i++) begin
         down_pulse = 1'b1;
         tick();
         down_pulse = 1'b0;
         tick();
      end
      wait_fs("f4");
      chk("f4_level", 32'(level), BR ? 0 : 4);
      tick();
      chk("f4_data", 32'(ser_data), BR ? 32'h0F0804 : 32'hFF8040);
      ser_ready = 1'b0;
      tick();
      ser_ready = 1'b1;
      tick();
      ser_ready = 1'b0;
      tick();
      chk("send1_idx", 32'(pix_idx), 1);
      chk("send1_valid", 32'(ser_valid), 1);
      rst = 1'b1;
      tick();
      chk_reset("rst1");
      rst = 1'b0; pix_ack = 1'b0;
      tick();
      chk("restart_fs", 32'(frame_start), 1);
      chk("restart_idx", 32'(pix_idx), 0);
      chk("restart_req", 32'(pix_req), 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/npx_frame_scheduler.md
# npx_frame_scheduler

Sequences one complete NeoPixel strip refresh per frame. For each LED it requests a 24-bit GRB word from the pattern source, applies the current brightness level, and hands the word to the WS2812B bit serializer. It then enforces the latch gap before the next frame starts. Brightness steps come from the up/down button controllers and take effect only at a frame boundary.

## Interface
- `NUM_LEDS`, default 60: LEDs per frame; legal range 1–255.
- `LATCH_CYCLES`, default 1024: low-time clocks between frames (≈85 µs at 12 MHz); must be ≥ 1.
- `LEVEL_RESET`, default 2: brightness level loaded at reset; legal range 0–4.
- `clk`, in, 1: 12 MHz system clock; all logic on rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `up_pulse`, in, 1: one-cycle brightness-up request from the up button controller.
- `down_pulse`, in, 1: one-cycle brightness-down request from the down button controller.
- `pix_req`, out, 1: pixel request to the pattern source.
- `pix_idx`, out, 8: LED index being requested.
- `pix_ack`, in, 1: pattern source response; `pix_grb` is valid in the same cycle.
- `pix_grb`, in, 24: G[23:16], R[15:8], B[7:0].
- `ser_valid`, out, 1: word available to the serializer.
- `ser_data`, out, 24: scaled GRB word.
- `ser_ready`, in, 1: serializer accepts the word in the cycle where valid and ready are both high.
- `latch`, out, 1: high during the latch gap; the serializer drives the line low while it is high.
- `frame_start`, out, 1: one-cycle pulse when LED 0 is first requested.
- `level`, out, 3: applied brightness level, 0–4; feeds the 7-segment display.

## Operation
- States:
  - IDLE: entered by reset. Moves to FETCH on the next cycle, with `pix_idx`=0 and `frame_start` pulsed.
  - FETCH: hold `pix_req`=1 and `pix_idx` stable until `pix_ack`. On ack, capture the scaled `pix_grb` into `ser_data` and go to SEND.
  - SEND: hold `ser_valid`=1 and `ser_data` stable until `ser_ready`.
    - On accept with `pix_idx`<`NUM_LEDS`-1: increment `pix_idx` and go to FETCH.
    - On accept at the last index: go to LATCH.
  - LATCH: `latch`=1. Count `LATCH_CYCLES` clocks, then apply the pending level, clear `pix_idx`, pulse `frame_start`, and go to FETCH.
- Brightness:
  - `pending_level` saturates at 0 and 4.
  - `up_pulse` alone: +1. `down_pulse` alone: −1. Both in the same cycle: no change.
  - `level` copies `pending_level` only at the LATCH→FETCH transition. A frame never mixes two levels.
- Scaling: each 8-bit channel is shifted right by (4 − `level`). Level 4 = raw value; level 0 = value >> 4. Result stays 8 bits with zero fill; no rounding.
- `pix_ack` outside FETCH is ignored. `ser_ready` outside SEND is ignored.
- `pix_idx` never reaches `NUM_LEDS`. With `NUM_LEDS`=1 the sequence is FETCH→SEND→LATCH every frame.
- Reset mid-operation:
  - Any state returns to IDLE on the next edge.
  - `ser_valid`, `pix_req` and `latch` drop; any in-flight word is discarded.
  - `pending_level` and `level` reload `LEVEL_RESET`.

## Timing
- Reset values:
  - `pix_req`=0, `pix_idx`=0, `ser_valid`=0, `ser_data`=0, `latch`=0, `frame_start`=0.
  - `level` and `pending_level` = `LEVEL_RESET`.
- All outputs are registered.
- `frame_start` and `pix_req` for LED 0 rise on the same edge.
- Ack-to-valid latency: `pix_ack` sampled at edge N → `ser_valid`=1 after edge N.
- Accept-to-next-request: `ser_ready` sampled at edge N → `pix_req`=1 with the new index after edge N. Minimum 2 cycles per LED when ack and ready are immediate.
- Latch length: exactly `LATCH_CYCLES` cycles with `latch`=1.
- Level latency: a button pulse reaches `level` at the next frame boundary, never earlier. The pulse is not lost even if it arrives during LATCH.

## Configuration
- `NPX_BRIGHTNESS_EN` defined: scaling and level tracking as described above.
- `NPX_BRIGHTNESS_EN` undefined:
  - `ser_data` = raw `pix_grb`.
  - `level` is tied to 4.
  - `up_pulse` and `down_pulse` are ignored.
  - Handshake and timing are unchanged.

## Structure
- Shared package `npx_pkg`:
  - state encoding;
  - `LEVEL_MAX`=4;
  - GRB field offsets;
  - shift-by-level function, shared with any future preview path.
- One sub-module, `npx_level_scale`: combinational 24-bit GRB × level shifter. Reused by the test-pattern generator.

## Test plan
- Reset, `NUM_LEDS`=3, ack and ready tied high → `frame_start` once, `pix_idx` 0,1,2, then 1024 `latch` cycles, then `frame_start` again.
- `level`=4, `pix_grb`=24'hFF8040 → `ser_data`=24'hFF8040. After 4 down pulses and a frame boundary → `ser_data`=24'h0F0804.
- `ser_ready` held low 10 cycles in SEND → `ser_valid` and `ser_data` stable; no new `pix_req` until accept.
- Up pulse mid-frame at `level`=2 → `level` stays 2 until LATCH ends, then 3. Up and down in the same cycle → no change. Six up pulses → saturates at 4.
- `rst` asserted in SEND at `pix_idx`=1 → next cycle all outputs at reset values; `level`=`LEVEL_RESET`; the restart begins at LED 0.
- Build without `NPX_BRIGHTNESS_EN`, `pix_grb`=24'h123456 with up/down pulses applied → `ser_data`=24'h123456, `level`=4 throughout.
